cbus_mst_arb: RTL

//  Round-robin arbiter sharing one CBUS master port between MST_NUM requesting masters
//  (CPU bridge, debug/JTAG, DMA config engine, ...). Sits upstream of the CBUS address

---
 rtl/cbus_pkg.sv | 18 +
 rtl/cbus_rr_pick.sv | 34 +++
 rtl/cbus_mst_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cbus_pkg.sv
// Shared types and constants for the CBUS master arbiter: FSM encoding,
// default timeout read data and a width helper.
package cbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } cbus_arb_state_e;

  localparam logic [31:0] CBUS_TMO_RDATA = 32'hDEAD_BEEF;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr,
// wrapping at MST_NUM, returned one-hot with a valid flag.
module cbus_rr_pick
  import cbus_pkg::*;
#(
  parameter int MST_NUM = 4,
  parameter int PTR_W   = clog2_min1(MST_NUM)
) (
  input  logic [MST_NUM-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [MST_NUM-1:0] gnt,
  output logic               vld
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < MST_NUM; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= MST_NUM) j = j - MST_NUM;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign vld = |req;

endmodule

// File: rtl/cbus_mst_arb.sv
// Round-robin arbiter sharing one CBUS master port, one transaction at a time.
// Optional watchdog on the downstream access is enabled by CBUS_ARB_TIMEOUT_EN.
module cbus_mst_arb
  import cbus_pkg::*;
#(
  parameter int                ADDR_W    = 20,
  parameter int                DATA_W    = 32,
  parameter int                MST_NUM   = 4,
  parameter int                TMO_CYC   = 256,
  parameter logic [DATA_W-1:0] TMO_RDATA = DATA_W'(CBUS_TMO_RDATA)
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst_sys,
  input  logic [MST_NUM-1:0]        i_cbus_mst_req,
  input  logic [MST_NUM-1:0]        i_cbus_mst_rw,
  input  logic [MST_NUM*ADDR_W-1:0] i_cbus_mst_addr,
  input  logic [MST_NUM*DATA_W-1:0] i_cbus_mst_wdata,
  output logic [MST_NUM-1:0]        o_cbus_mst_ack,
  output logic [DATA_W-1:0]         o_cbus_mst_rdata,
  output logic [MST_NUM-1:0]        o_cbus_grant,
  output logic                      o_cbus_tmo,
  output logic                      o_cbus_req,
  output logic                      o_cbus_rw,
  output logic [ADDR_W-1:0]         o_cbus_addr,
  output logic [DATA_W-1:0]         o_cbus_wdata,
  input  logic                      i_cbus_ack,
  input  logic [DATA_W-1:0]         i_cbus_rdata
);

  localparam int PTR_W = clog2_min1(MST_NUM);

  cbus_arb_state_e     state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [MST_NUM-1:0]  grant_q, grant_d;
  logic [MST_NUM-1:0]  ack_q, ack_d;
  logic                req_q, req_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                tmo_q, tmo_d;
  logic                tmo_hit;

  logic [MST_NUM-1:0]  pick_gnt;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_rw;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  cbus_rr_pick #(
    .MST_NUM (MST_NUM),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (i_cbus_mst_req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .vld    (pick_vld)
  );

  // Winner's index and transaction fields, muxed by the one-hot pick.
  always_comb begin
    pick_idx   = '0;
    pick_rw    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < MST_NUM; i++) begin
      if (pick_gnt[i]) begin
        pick_idx   = PTR_W'(i);
        pick_rw    = i_cbus_mst_rw[i];
        pick_addr  = i_cbus_mst_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = i_cbus_mst_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2_min1(TMO_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && pick_vld) cnt_d = '0;
    else if (state_q == ST_BUSY)        cnt_d = cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == ST_BUSY) && (cnt_q == CNT_W'(TMO_CYC - 1));

  always_ff @(posedge i_clk_sys or posedge i_rst_sys) begin
    if (i_rst_sys) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Downstream ack has priority over the watchdog in the same cycle.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    grant_d   = grant_q;
    ack_d     = '0;
    req_d     = req_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tmo_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d   = pick_gnt;
          gnt_idx_d = pick_idx;
          rw_d      = pick_rw;
          addr_d    = pick_addr;
          wdata_d   = pick_wdata;
          req_d     = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_cbus_ack) begin
          rdata_d = i_cbus_rdata;
          req_d   = 1'b0;
          ack_d   = grant_q;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          rdata_d = TMO_RDATA;
          req_d   = 1'b0;
          ack_d   = grant_q;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        grant_d  = '0;
        rr_ptr_d = (gnt_idx_q == PTR_W'(MST_NUM - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or posedge i_rst_sys) begin
    if (i_rst_sys) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      req_q     <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      req_q     <= req_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_cbus_mst_ack   = ack_q;
  assign o_cbus_mst_rdata = rdata_q;
  assign o_cbus_grant     = grant_q;
  assign o_cbus_tmo       = tmo_q;
  assign o_cbus_req       = req_q;
  assign o_cbus_rw        = rw_q;
  assign o_cbus_addr      = addr_q;
  assign o_cbus_wdata     = wdata_q;

endmodule
